gpu_rect_fill: RTL and testbench
================================

Name: gpu_rect_fill

Overview:
- Upstream companion to the GPU video-memory write port. It accepts a rectangle-fill command from the CPU MMIO decoder and streams one 8-bit pixel write per cycle into VRAM port 2.
- It merges CPU direct VRAM writes onto the same port, and CPU writes always take priority.
- Its outputs drive the GPU's v_we_i, v_addr_i and v_data_i directly.
- This offloads solid-colour clears and boxes from the multicycle CPU.

Parameters:
- FB_W, 80, framebuffer width in pixels; linear address = y*FB_W + x.
- FB_H, 60, framebuffer height in pixels; FB_W*FB_H must be 8192 or less.
- ADDR_W, 13, VRAM write-address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle command strobe; sampled only when busy_o=0
- x0_i  in  8  rectangle left column
- y0_i  in  8  rectangle top row
- w_i  in  8  width in pixels
- h_i  in  8  height in pixels
- color_i  in  8  fill pixel value (RGB332)
- cpu_we_i  in  1  CPU direct VRAM write strobe
- cpu_addr_i  in  ADDR_W  CPU write address
- cpu_data_i  in  8  CPU write data
- busy_o  out  1  high from the cycle after start is accepted until done_o
- done_o  out  1  one-cycle completion pulse
- v_we_o  out  1  VRAM write enable (to GPU v_we_i)
- v_addr_o  out  ADDR_W  VRAM address (to GPU v_addr_i)
- v_data_o  out  8  VRAM data (to GPU v_data_i)

Behaviour:
- Reset: state IDLE; busy_o, done_o and v_we_o are 0; v_addr_o and v_data_o are 0; all counters are 0. Reset is asynchronous and takes effect mid-fill; the aborted fill is not resumed and done_o does not pulse.
- All outputs are registered. A write presented on cpu_* at edge E appears on v_*_o after edge E, so CPU pass-through latency is 1 cycle.
- FSM, one transition per clock edge:
  - IDLE: on start_i=1, latch x0, y0, w, h and color, then go to SETUP. busy_o=1 from the next cycle.
  - SETUP: clip the rectangle using 9-bit arithmetic.
    - x_end = min(x0+w, FB_W); y_end = min(y0+h, FB_H).
    - If w=0, h=0, x0>=FB_W or y0>=FB_H, the pixel count is zero: go to DONE.
    - Otherwise row_base = y0*FB_W (the only multiply; one cycle), col=x0, row=y0, then go to FILL.
  - FILL: each cycle with cpu_we_i=0, register v_we_o=1, v_addr_o=row_base+col, v_data_o=color.
    - Then col++. When col+1=x_end: col=x0, row++, row_base+=FB_W.
    - When the last pixel issues (col+1=x_end and row+1=y_end), go to DONE.
  - DONE: done_o=1 for one cycle, busy_o=0, return to IDLE. start_i in this cycle is ignored.
- Arbitration: if cpu_we_i=1 in any state, the CPU write wins that cycle. The fill engine stalls and holds col, row and row_base. No fill pixel is dropped or duplicated.
- start_i while busy_o=1 or in SETUP/DONE is ignored; the latched command is unchanged.
- Pixel order is row-major, left to right then top to bottom.
- Throughput: with no CPU contention, a clipped area of N pixels gives writes on N consecutive cycles. The first fill write is visible 2 edges after the edge that samples start_i (SETUP plus FILL register). done_o is asserted the cycle after the last fill write is visible.
- Address width: row_base+col fits ADDR_W by construction because of clipping, so there is no wrap-around.
- v_we_o=0 whenever no write is issued. v_addr_o and v_data_o hold their last value.

Decomposition:
- Shared gpu package holds: FB_W, FB_H, ADDR_W, PIX_W=8, and the fill FSM state enum (IDLE, SETUP, FILL, DONE).
- One natural sub-module: gpu_wr_arb. It is a 2:1 registered write mux, CPU over fill, and returns a fill_grant signal used as the stall. The FSM and the clip/address counters stay in gpu_rect_fill.

Test Plan:
- Basic fill: start x0=1, y0=1, w=2, h=2, color=0xE0 -> writes to 81, 82, 161, 162 on 4 consecutive cycles with data 0xE0; done_o pulses once; busy_o falls with done_o.
- Clipping: x0=78, y0=59, w=5, h=3, color=0x1C -> only addresses 4798 and 4799 are written, then done_o.
- Degenerate cases: w=0, then x0=80 -> zero VRAM writes; done_o is asserted 2 cycles after start is sampled.
- Contention: during fill x0=0, y0=0, w=4, h=1, drive cpu_we_i=1, addr=100, data=0x03 on the second fill cycle -> v_* sequence is 0, 100(0x03), 1, 2, 3; 5 total writes.
- Ignored start: pulse start_i with new operands mid-fill -> the original rectangle completes unchanged and there is exactly one done_o.
- Reset mid-op: assert rst_n=0 during FILL -> v_we_o, busy_o and done_o go 0 immediately; after release the FSM is in IDLE and a fresh start fills correctly.

Source files
------------

// File: rtl/gpu_rect_fill_pkg.sv
// Shared framebuffer geometry, fill FSM state encoding and command record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gpu_rect_fill_pkg;

    localparam int FB_W   = 80;
    localparam int FB_H   = 60;
    localparam int ADDR_W = 13;
    localparam int PIX_W  = 8;

    // 9-bit forms of the framebuffer limits so clip compares stay width-matched
    localparam logic [8:0]        FB_W9  = 9'(FB_W);
    localparam logic [8:0]        FB_H9  = 9'(FB_H);
    localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_FILL,
        ST_DONE
    } fill_state_e;

    typedef struct packed {
        logic [7:0]       x0;
        logic [7:0]       y0;
        logic [7:0]       w;
        logic [7:0]       h;
        logic [PIX_W-1:0] color;
    } fill_cmd_t;

    // Exclusive end coordinate of a span, clipped to the framebuffer edge (9-bit sum cannot overflow)
    function automatic logic [8:0] clip_end(input logic [7:0] org, input logic [7:0] len,
                                            input logic [8:0] lim);
        logic [8:0] sum;
        sum = {1'b0, org} + {1'b0, len};
        return (sum > lim) ? lim : sum;
    endfunction

endpackage

// File: rtl/gpu_wr_arb.sv
// Registered 2:1 VRAM write mux; CPU writes always beat fill writes.
// Latency: 1 cycle from request to v_*_o.
// Backpressure: fill_grant_o is low whenever the CPU writes; the fill engine must hold its pixel.
module gpu_wr_arb
    import gpu_rect_fill_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [PIX_W-1:0]  cpu_data_i,
    input  logic              fill_req_i,
    input  logic [ADDR_W-1:0] fill_addr_i,
    input  logic [PIX_W-1:0]  fill_data_i,
    output logic              fill_grant_o,
    output logic              v_we_o,
    output logic [ADDR_W-1:0] v_addr_o,
    output logic [PIX_W-1:0]  v_data_o
);

    logic              v_we_q, v_we_d;
    logic [ADDR_W-1:0] v_addr_q, v_addr_d;
    logic [PIX_W-1:0]  v_data_q, v_data_d;

    assign fill_grant_o = ~cpu_we_i;

    // Pick the winning writer; address/data hold their last value when nobody writes
    always_comb begin
        v_we_d   = 1'b0;
        v_addr_d = v_addr_q;
        v_data_d = v_data_q;
        if (cpu_we_i) begin
            v_we_d   = 1'b1;
            v_addr_d = cpu_addr_i;
            v_data_d = cpu_data_i;
        end else if (fill_req_i) begin
            v_we_d   = 1'b1;
            v_addr_d = fill_addr_i;
            v_data_d = fill_data_i;
        end
    end

    // Output register feeding the VRAM write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_we_q   <= 1'b0;
            v_addr_q <= '0;
            v_data_q <= '0;
        end else begin
            v_we_q   <= v_we_d;
            v_addr_q <= v_addr_d;
            v_data_q <= v_data_d;
        end
    end

    assign v_we_o   = v_we_q;
    assign v_addr_o = v_addr_q;
    assign v_data_o = v_data_q;

endmodule

// File: rtl/gpu_rect_fill.sv
// Rectangle-fill engine: clips a box to the framebuffer and streams one pixel write per cycle.
// Latency: first write visible 2 edges after start is sampled; done_o one cycle after the last write.
// Backpressure: stalls (holds col/row/row_base) on any cycle the CPU writes VRAM.
module gpu_rect_fill
    import gpu_rect_fill_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [7:0]        x0_i,
    input  logic [7:0]        y0_i,
    input  logic [7:0]        w_i,
    input  logic [7:0]        h_i,
    input  logic [PIX_W-1:0]  color_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [PIX_W-1:0]  cpu_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              v_we_o,
    output logic [ADDR_W-1:0] v_addr_o,
    output logic [PIX_W-1:0]  v_data_o
);

    fill_state_e       state_q, state_d;
    fill_cmd_t         cmd_q;
    logic [8:0]        x_end_q, y_end_q, col_q, row_q;
    logic [ADDR_W-1:0] row_base_q;
    logic              busy_q, busy_d, done_q, done_d;
    logic              fill_req, fill_grant, fill_adv;
    logic              last_col, last_row, empty_c;
    logic [8:0]        x_end_c, y_end_c;
    logic [ADDR_W-1:0] fill_addr;

    assign x_end_c   = clip_end(cmd_q.x0, cmd_q.w, FB_W9);
    assign y_end_c   = clip_end(cmd_q.y0, cmd_q.h, FB_H9);
    assign empty_c   = (cmd_q.w == 8'd0) || (cmd_q.h == 8'd0) ||
                       ({1'b0, cmd_q.x0} >= FB_W9) || ({1'b0, cmd_q.y0} >= FB_H9);
    assign last_col  = (col_q + 9'd1) == x_end_q;
    assign last_row  = (row_q + 9'd1) == y_end_q;
    assign fill_adv  = fill_req & fill_grant;
    assign fill_addr = row_base_q + ADDR_W'(col_q);

    // State register plus registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state: start is only honoured in IDLE; FILL exits after the last granted pixel
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_SETUP;
            ST_SETUP: state_d = empty_c ? ST_DONE : ST_FILL;
            ST_FILL:  if (fill_adv && last_col && last_row) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs: done registers on leaving DONE so it lands with busy falling
    always_comb begin
        fill_req = (state_q == ST_FILL);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_q == ST_DONE);
    end

    // Command latch, clip setup and raster counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q      <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        cmd_q <= '{x0: x0_i, y0: y0_i, w: w_i, h: h_i, color: color_i};
                    end
                end
                ST_SETUP: begin
                    x_end_q <= x_end_c;
                    y_end_q <= y_end_c;
                    if (!empty_c) begin
                        col_q      <= {1'b0, cmd_q.x0};
                        row_q      <= {1'b0, cmd_q.y0};
                        row_base_q <= ADDR_W'(cmd_q.y0) * FB_W_A;
                    end
                end
                ST_FILL: begin
                    if (fill_adv) begin
                        if (last_col) begin
                            col_q      <= {1'b0, cmd_q.x0};
                            row_q      <= row_q + 9'd1;
                            row_base_q <= row_base_q + FB_W_A;
                        end else begin
                            col_q <= col_q + 9'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    gpu_wr_arb u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_we_i     (cpu_we_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_data_i   (cpu_data_i),
        .fill_req_i   (fill_req),
        .fill_addr_i  (fill_addr),
        .fill_data_i  (cmd_q.color),
        .fill_grant_o (fill_grant),
        .v_we_o       (v_we_o),
        .v_addr_o     (v_addr_o),
        .v_data_o     (v_data_o)
    );

    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_gpu_rect_fill.sv
// Bench for gpu_rect_fill: event-level model compared every cycle, plus literal expectations.
// Latency: n/a.
// Backpressure: CPU contention injected at chosen cycles.
module tb_gpu_rect_fill;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        start_i    = 1'b0;
    logic [7:0]  x0_i       = '0;
    logic [7:0]  y0_i       = '0;
    logic [7:0]  w_i        = '0;
    logic [7:0]  h_i        = '0;
    logic [7:0]  color_i    = '0;
    logic        cpu_we_i   = 1'b0;
    logic [12:0] cpu_addr_i = '0;
    logic [7:0]  cpu_data_i = '0;
    logic        busy_o, done_o, v_we_o;
    logic [12:0] v_addr_o;
    logic [7:0]  v_data_o;

    int checks = 0;
    int errors = 0;

    gpu_rect_fill dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .x0_i       (x0_i),
        .y0_i       (y0_i),
        .w_i        (w_i),
        .h_i        (h_i),
        .color_i    (color_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_i (cpu_data_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .v_we_o     (v_we_o),
        .v_addr_o   (v_addr_o),
        .v_data_o   (v_data_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Expected pixel list comes straight from the clipped rectangle; timing is expressed
    // as edges elapsed since the accepted start.
    logic        e_we = 1'b0, e_busy = 1'b0, e_done = 1'b0;
    logic [12:0] e_addr = '0;
    logic [7:0]  e_data = '0;
    int          pend[$];
    logic [7:0]  m_color = '0;
    bit          m_busy = 1'b0, m_fin = 1'b0;
    int          m_lat = 0;

    task automatic build(input int x0, input int y0, input int w, input int h);
        pend.delete();
        for (int y = y0; y < y0 + h && y < 60; y++)
            for (int x = x0; x < x0 + w && x < 80; x++)
                pend.push_back(y * 80 + x);
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            pend.delete();
            m_busy = 1'b0; m_fin = 1'b0; m_lat = 0;
            e_we = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_addr = '0; e_data = '0;
        end else begin
            e_we   = 1'b0;
            e_done = 1'b0;
            if (cpu_we_i) begin
                e_we = 1'b1; e_addr = cpu_addr_i; e_data = cpu_data_i;
            end else if (m_busy && m_lat >= 2 && pend.size() > 0) begin
                e_we = 1'b1; e_addr = 13'(pend.pop_front()); e_data = m_color;
            end
            if (m_busy) begin
                if (m_fin) begin
                    e_done = 1'b1; e_busy = 1'b0; m_busy = 1'b0;
                end else begin
                    if (m_lat >= 1 && pend.size() == 0) m_fin = 1'b1;
                    m_lat++;
                end
            end else if (start_i) begin
                build(int'(x0_i), int'(y0_i), int'(w_i), int'(h_i));
                m_color = color_i; m_busy = 1'b1; m_fin = 1'b0; m_lat = 1; e_busy = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle
    always @(negedge clk) begin
        chk("v_we", v_we_o, e_we);
        chk("v_addr", v_addr_o, e_addr);
        chk("v_data", v_data_o, e_data);
        chk("busy", busy_o, e_busy);
        chk("done", done_o, e_done);
    end

    // ---------------- directed stimulus ----------------
    int log_a[$], log_d[$], exp_a[$], exp_d[$];
    int done_cnt, done_k, first_k;
    logic busy_k1, busy_at_done;

    task automatic run_cmd(input logic [7:0] x0, input logic [7:0] y0, input logic [7:0] w,
                           input logic [7:0] h, input logic [7:0] c, input int cpu_k, input int st2_k);
        @(negedge clk);
        start_i = 1'b1; x0_i = x0; y0_i = y0; w_i = w; h_i = h; color_i = c;
        log_a.delete(); log_d.delete();
        done_cnt = 0; done_k = -1; first_k = -1; busy_k1 = 1'b0; busy_at_done = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            start_i  = 1'b0;
            cpu_we_i = 1'b0;
            if (k == cpu_k) begin cpu_we_i = 1'b1; cpu_addr_i = 13'd100; cpu_data_i = 8'h03; end
            if (k == st2_k) begin
                start_i = 1'b1; x0_i = 8'd0; y0_i = 8'd0; w_i = 8'd10; h_i = 8'd10; color_i = 8'hFF;
            end
            if (k == 1) busy_k1 = busy_o;
            if (v_we_o) begin
                log_a.push_back(int'(v_addr_o)); log_d.push_back(int'(v_data_o));
                if (first_k < 0) first_k = k;
            end
            if (done_o) begin
                done_cnt++;
                if (done_k < 0) begin done_k = k; busy_at_done = busy_o; end
            end
            if (done_k >= 0 && k >= done_k + 3) break;
        end
        start_i = 1'b0; cpu_we_i = 1'b0;
    endtask

    task automatic chk_log(input string tag);
        chk({tag, "_nwr"}, log_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < log_a.size(); i++) begin
            chk({tag, "_addr"}, log_a[i], exp_a[i]);
            chk({tag, "_data"}, log_d[i], exp_d[i]);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_we", v_we_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_addr", v_addr_o, 13'd0);
        chk("rst_data", v_data_o, 8'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        // basic 2x2 fill
        run_cmd(8'd1, 8'd1, 8'd2, 8'd2, 8'hE0, -1, -1);
        exp_a = '{81, 82, 161, 162}; exp_d = '{'hE0, 'hE0, 'hE0, 'hE0};
        chk_log("basic");
        chk("basic_first_k", first_k, 3);
        chk("basic_done_k", done_k, 7);
        chk("basic_done_cnt", done_cnt, 1);
        chk("basic_busy_k1", busy_k1, 1'b1);
        chk("basic_busy_at_done", busy_at_done, 1'b0);

        // clipped at the bottom-right corner
        run_cmd(8'd78, 8'd59, 8'd5, 8'd3, 8'h1C, -1, -1);
        exp_a = '{4798, 4799}; exp_d = '{'h1C, 'h1C};
        chk_log("clip");
        chk("clip_done_k", done_k, 5);
        chk("clip_done_cnt", done_cnt, 1);

        // degenerate: zero width, then off-screen origin
        run_cmd(8'd3, 8'd3, 8'd0, 8'd4, 8'h11, -1, -1);
        chk("w0_nwr", log_a.size(), 0);
        chk("w0_done_k", done_k, 3);
        chk("w0_done_cnt", done_cnt, 1);
        run_cmd(8'd80, 8'd2, 8'd4, 8'd4, 8'h22, -1, -1);
        chk("x80_nwr", log_a.size(), 0);
        chk("x80_done_k", done_k, 3);

        // CPU write steals the second fill slot
        run_cmd(8'd0, 8'd0, 8'd4, 8'd1, 8'h55, 3, -1);
        exp_a = '{0, 100, 1, 2, 3}; exp_d = '{'h55, 'h03, 'h55, 'h55, 'h55};
        chk_log("contend");
        chk("contend_done_k", done_k, 8);
        chk("contend_done_cnt", done_cnt, 1);

        // start mid-fill must be ignored
        run_cmd(8'd2, 8'd3, 8'd3, 8'd2, 8'h0F, -1, 4);
        exp_a = '{242, 243, 244, 322, 323, 324}; exp_d = '{'h0F, 'h0F, 'h0F, 'h0F, 'h0F, 'h0F};
        chk_log("ignstart");
        chk("ignstart_done_cnt", done_cnt, 1);

        // asynchronous reset during FILL
        @(negedge clk);
        start_i = 1'b1; x0_i = 8'd0; y0_i = 8'd0; w_i = 8'd20; h_i = 8'd2; color_i = 8'hAA;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        chk("rstmid_pre_we", v_we_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_we", v_we_o, 1'b0);
        chk("rstmid_busy", busy_o, 1'b0);
        chk("rstmid_done", done_o, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_cmd(8'd5, 8'd0, 8'd1, 8'd1, 8'h77, -1, -1);
        exp_a = '{5}; exp_d = '{'h77};
        chk_log("after_rst");
        chk("after_rst_done_k", done_k, 4);
        chk("after_rst_done_cnt", done_cnt, 1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
